ram_readback_checker: RTL and testbench

- Read-side counterpart to the integer-pattern RAM fill.
- Sweeps a programmable address window of the RAM with r_wn held high (read) and compares each returned word against the integer pattern, where the expected value is the address zero-extended to the data width.
- Reports a pass/fail verdict, the mismatch count, and the first failing address and data.
- Sits between a control/bench master and the RAM's address/r_wn/data_out pins.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_expect_pipe.sv | 42 ++++
 rtl/ram_readback_checker.sv | 121 ++++++++++++
 tb/tb_ram_readback_checker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and defaults for the RAM fill/check blocks.
// Pure declarations: no logic, no latency, no flow control.
package ram_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int RAM_DEPTH  = 2 ** DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_expect_pipe.sv
// Valid + expected-value delay line matching the RAM read latency (DEPTH cycles).
// No backpressure: one entry may be pushed every cycle.
module ram_expect_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         exp_vld,
  output logic [W-1:0] exp_dat,
  output logic         pending
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      vld[0] <= push_vld;
      dat[0] <= push_dat;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign exp_vld = vld[DEPTH-1];
  assign exp_dat = dat[DEPTH-1];

  // Entries still in flight behind the one being compared this cycle.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pending = pending | vld[i];
  end

endmodule

// File: rtl/ram_readback_checker.sv
// Sweeps a RAM window reading one word per cycle and checks each word equals its address.
// Done N+READ_LATENCY+1 cycles after start (1 cycle for N=0); start while busy is ignored.
module ram_readback_checker
  import ram_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              ram_r_wn,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   remaining;
  logic              accept, done_set, issue, last_issue;
  logic              chk_vld, pending, mismatch;
  logic [DATA_W-1:0] chk_dat;
  logic [ADDR_W:0]   err_nxt;

  assign ram_r_wn   = 1'b1;
  assign busy       = (state == ISSUE) || (state == DRAIN);
  assign issue      = (state == ISSUE);
  assign last_issue = issue && (remaining == (ADDR_W+1)'(1));
  assign mismatch   = chk_vld && (ram_data_out != chk_dat);
  assign err_nxt    = err_count + (ADDR_W+1)'(mismatch);

  ram_expect_pipe #(
    .DEPTH (READ_LATENCY),
    .W     (DATA_W)
  ) u_expect_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (issue),
    .push_dat (DATA_W'(ram_address)),
    .exp_vld  (chk_vld),
    .exp_dat  (chk_dat),
    .pending  (pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept = 1'b1;
          if (num_words == '0) begin
            state_nxt = DONE;
            done_set  = 1'b1;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: if (last_issue) state_nxt = DRAIN;
      DRAIN: begin
        if (!pending) begin
          state_nxt = DONE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_address    <= '0;
      remaining      <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      done <= done_set;
      if (accept) begin
        remaining      <= num_words;
        err_count      <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
        pass           <= (num_words == '0);
        if (num_words != '0) ram_address <= start_addr;
      end else begin
        if (issue) begin
          remaining <= remaining - (ADDR_W+1)'(1);
          // Stop advancing on the last word so the address holds its final value.
          if (!last_issue) ram_address <= ram_address + ADDR_W'(1);
        end
        if (mismatch) begin
          err_count <= err_nxt;
          if (err_count == '0) begin
            first_err_addr <= ADDR_W'(chk_dat);
            first_err_data <= ram_data_out;
          end
        end
        if (state == DRAIN && !pending) pass <= (err_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_ram_readback_checker.sv
// Randomised scoreboard bench: a reference model predicts each sweep's verdict and timing,
// monitors pop and compare on every done pulse of the latency-1 and latency-3 instances.
module tb_ram_readback_checker;

  localparam int AW = 12;
  localparam int DW = 32;

  typedef struct {
    int          c0;
    int          cycles;
    logic        pass;
    int          errs;
    int          fa;
    logic [31:0] fd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start, start3;
  logic [AW-1:0] start_addr;
  logic [AW:0]   num_words;

  logic          r_wn1, busy1, done1, pass1;
  logic [AW-1:0] addr1, fa1;
  logic [DW-1:0] rdata1, fd1;
  logic [AW:0]   err1;

  logic          r_wn3, busy3, done3, pass3;
  logic [AW-1:0] addr3, fa3;
  logic [DW-1:0] r3a, r3b, rdata3, fd3;
  logic [AW:0]   err3;

  logic [DW-1:0] mem [4096];
  exp_t          q1[$], q3[$];
  exp_t          e1, e3;
  int            n_cmp = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: latency 1 and latency 3.
  always @(posedge clk) rdata1 <= mem[addr1];
  always @(posedge clk) begin
    r3a    <= mem[addr3];
    r3b    <= r3a;
    rdata3 <= r3b;
  end

  ram_readback_checker #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .num_words(num_words),
    .ram_r_wn(r_wn1), .ram_address(addr1), .ram_data_out(rdata1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .first_err_addr(fa1), .first_err_data(fd1));

  ram_readback_checker #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .start_addr(start_addr), .num_words(num_words),
    .ram_r_wn(r_wn3), .ram_address(addr3), .ram_data_out(rdata3), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err3), .first_err_addr(fa3), .first_err_data(fd3));

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: walk the window over the memory image and compare with the integer pattern.
  function automatic exp_t model(input int sa, input int nw, input int lat);
    exp_t e;
    e.c0 = 0; e.errs = 0; e.fa = 0; e.fd = '0;
    for (int i = 0; i < nw; i++) begin
      int a;
      a = (sa + i) % 4096;
      if (mem[a] != DW'(a)) begin
        if (e.errs == 0) begin
          e.fa = a;
          e.fd = mem[a];
        end
        e.errs++;
      end
    end
    e.pass   = (e.errs == 0);
    e.cycles = (nw == 0) ? 1 : nw + lat + 1;
    return e;
  endfunction

  // Drives a start pulse and returns at the falling edge of the first cycle after it.
  task automatic start_sweep(input int sa, input int nw, input bit on3, input bit expect_it);
    exp_t e;
    @(negedge clk);
    start_addr = AW'(sa);
    num_words  = (AW+1)'(nw);
    e    = model(sa, nw, on3 ? 3 : 1);
    e.c0 = cyc;
    if (on3) start3 = 1'b1;
    else     start  = 1'b1;
    if (expect_it) begin
      if (on3) q3.push_back(e);
      else     q1.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0 || q3.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sweep_timeout: %0d sweeps outstanding after %0d cycles", q1.size() + q3.size(), budget);
      q1.delete();
      q3.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: done pulse with no sweep outstanding (t=%0t)", $time);
      end else begin
        e1 = q1.pop_front();
        chk("done_cycle", cyc - e1.c0, e1.cycles);
        chk("pass", pass1, e1.pass);
        chk("err_count", err1, e1.errs);
        chk("first_err_addr", fa1, e1.fa);
        chk("first_err_data", fd1, e1.fd);
        chk("busy_at_done", busy1, 0);
        chk("ram_r_wn", r_wn1, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done3: done pulse with no sweep outstanding (t=%0t)", $time);
      end else begin
        e3 = q3.pop_front();
        chk("lat3_done_cycle", cyc - e3.c0, e3.cycles);
        chk("lat3_pass", pass3, e3.pass);
        chk("lat3_err_count", err3, e3.errs);
      end
    end
  end

  initial begin
    int sa, nw, k, a;
    logic [AW-1:0] a0;
    int ca[$];

    start = 1'b0; start3 = 1'b0; start_addr = '0; num_words = '0;
    for (int i = 0; i < 4096; i++) mem[i] = DW'(i);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_err_count", err1, 0);
    chk("rst_first_err_addr", fa1, 0);
    chk("rst_first_err_data", fd1, 0);
    chk("rst_ram_address", addr1, 0);
    chk("rst_ram_r_wn", r_wn1, 1);
    rst_n = 1'b1;

    // Clean full sweep, then single and double corruption.
    start_sweep(0, 4096, 0, 1);
    wait_idle(4200);
    mem['h123] = 32'hDEADBEEF;
    start_sweep(0, 4096, 0, 1);
    wait_idle(4200);
    mem['h123] = 32'h123;
    mem['h010] = 32'h0BAD0010;
    mem['h020] = 32'hFFFFFFFF;
    start_sweep(0, 'h40, 0, 1);
    wait_idle(100);
    mem['h010] = 32'h010;
    mem['h020] = 32'h020;

    // Wrap across the top of the address space.
    start_sweep('hFFE, 4, 0, 1);
    chk("wrap_addr0", addr1, 'hFFE);
    @(negedge clk) chk("wrap_addr1", addr1, 'hFFF);
    @(negedge clk) chk("wrap_addr2", addr1, 'h000);
    @(negedge clk) chk("wrap_addr3", addr1, 'h001);
    wait_idle(50);

    // Zero-length sweep leaves the address untouched.
    a0 = addr1;
    start_sweep('h555, 0, 0, 1);
    wait_idle(10);
    chk("zero_len_addr", addr1, a0);

    // Start while busy must be ignored, including the new parameters.
    start_sweep('h100, 300, 0, 1);
    repeat (50) @(negedge clk);
    start_addr = 'h800; num_words = 5; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle(400);

    // Reset around word 100 of a full sweep that has already seen an error.
    mem[5] = 32'h5A5A5A5A;
    start_sweep(0, 4096, 0, 0);
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy1, 0);
    chk("midrst_done", done1, 0);
    chk("midrst_pass", pass1, 0);
    chk("midrst_err_count", err1, 0);
    chk("midrst_first_err_addr", fa1, 0);
    chk("midrst_first_err_data", fd1, 0);
    chk("midrst_ram_address", addr1, 0);
    chk("midrst_ram_r_wn", r_wn1, 1);
    @(negedge clk) rst_n = 1'b1;
    mem[5] = 32'h5;
    repeat (20) @(negedge clk);
    start_sweep(0, 4096, 0, 1);
    wait_idle(4200);

    // Randomised windows with corruption biased into the window.
    for (int it = 0; it < 25; it++) begin
      sa = $urandom_range(0, 4095);
      nw = $urandom_range(0, 300);
      k  = $urandom_range(0, 3);
      ca.delete();
      for (int j = 0; j < k; j++) begin
        a = (sa + $urandom_range(0, nw + 5)) % 4096;
        ca.push_back(a);
        mem[a] = $urandom;
      end
      start_sweep(sa, nw, 0, 1);
      if ($urandom_range(0, 1) == 1 && busy1 === 1'b1) begin
        start_addr = AW'($urandom);
        num_words  = (AW+1)'($urandom_range(1, 50));
        start = 1'b1;
        @(negedge clk) start = 1'b0;
      end
      wait_idle(nw + 20);
      foreach (ca[j]) mem[ca[j]] = DW'(ca[j]);
    end

    // Latency-3 instance, full clean sweep.
    start_sweep(0, 4096, 1, 1);
    wait_idle(4300);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
